// File: rtl/data_memory_pkg.sv
// ----------------------------------------------------------------------------
// data_memory_pkg
// Purpose : shared constants and types for the data memory block.
//   WORD_W        - width of one stored word (32)
//   DEPTH_DEFAULT - default number of words (256)
//   word_t        - one memory word
//   ZERO_WORD     - all-zero word, used for cleared and gated read data
// ----------------------------------------------------------------------------
package data_memory_pkg;

    localparam int WORD_W        = 32;
    localparam int DEPTH_DEFAULT = 256;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t ZERO_WORD = '0;

endpackage : data_memory_pkg

// File: rtl/data_memory_if.sv
// ----------------------------------------------------------------------------
// data_memory_if
// Purpose : bus between a requester (master) and the data memory (slave).
// Signals :
//   addr     - 32-bit byte address (word index taken from addr[AW+1:2])
//   data     - 32-bit write data
//   MemRead  - read enable
//   MemWrite - write enable
//   DM_data  - 32-bit combinational read data
//   addr_err - out-of-range flag, only when DATA_MEMORY_BOUNDS_CHECK_EN is defined
// ----------------------------------------------------------------------------
interface data_memory_if;
    import data_memory_pkg::*;

    logic [31:0] addr;
    word_t       data;
    logic        MemRead;
    logic        MemWrite;
    word_t       DM_data;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    logic        addr_err;
`endif

    modport master (
        output addr, data, MemRead, MemWrite,
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        input  addr_err,
`endif
        input  DM_data
    );

    modport slave (
        input  addr, data, MemRead, MemWrite,
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        output addr_err,
`endif
        output DM_data
    );

endinterface : data_memory_if

// File: rtl/dm_ram_array.sv
// ----------------------------------------------------------------------------
// dm_ram_array
// Purpose : DEPTH x 32-bit register array with synchronous write, synchronous
//           whole-array clear and an asynchronous read port.
// Ports   :
//   clk     - rising-edge clock
//   i_clr   - synchronous clear of every word (has priority over i_we)
//   i_we    - write enable
//   i_addr  - word index for both write and read
//   i_wdata - write data
//   o_rdata - asynchronous read data of word i_addr
// ----------------------------------------------------------------------------
module dm_ram_array
    import data_memory_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          i_clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  word_t         i_wdata,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];

    // NOTE: state is updated with non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    // NOTE: this array is deliberately reset word by word because the block
    // must read zero after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= ZERO_WORD;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Asynchronous read: shows the pre-edge content until the clock edge
    // commits a write, then the new value.
    assign o_rdata = r_mem[i_addr];

endmodule : dm_ram_array

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
// Purpose : word-addressed 32-bit data memory with combinational read.
// Ports   :
//   clk  - rising-edge clock for all state
//   rst  - synchronous active-high reset, clears every word, beats MemWrite
//   bus  - data_memory_if.slave (addr, data, MemRead, MemWrite, DM_data,
//          and addr_err when enabled)
// Config  : define DATA_MEMORY_BOUNDS_CHECK_EN to flag and suppress accesses
//           with addr >= DEPTH*4; otherwise upper address bits are ignored and
//           addresses wrap modulo DEPTH*4.
// ----------------------------------------------------------------------------
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    data_memory_if.slave   bus
);

    logic [AW-1:0] w_word_idx;
    logic          w_we;
    logic          w_rd_en;
    word_t         w_rdata;

    // Byte address -> word index; the two low bits select a byte and are dropped.
    assign w_word_idx = bus.addr[AW+1:2];

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    logic       w_oob;
    logic [1:0] w_unused_addr;

    // With DEPTH = 2**AW, addr >= DEPTH*4 exactly when any bit above AW+1 is set.
    assign w_oob         = |bus.addr[31:AW+2];
    assign bus.addr_err  = w_oob & (bus.MemRead | bus.MemWrite);
    assign w_we          = bus.MemWrite & ~w_oob;
    assign w_rd_en       = bus.MemRead & ~w_oob;
    assign w_unused_addr = bus.addr[1:0];
`else
    logic [31-AW:0] w_unused_addr;

    // Upper bits are ignored, giving wrap-around modulo DEPTH*4.
    assign w_we          = bus.MemWrite;
    assign w_rd_en       = bus.MemRead;
    assign w_unused_addr = {bus.addr[31:AW+2], bus.addr[1:0]};
`endif

    dm_ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_clr   (rst),
        .i_we    (w_we),
        .i_addr  (w_word_idx),
        .i_wdata (bus.data),
        .o_rdata (w_rdata)
    );

    // NOTE: a continuous assign with both arms covered cannot infer a latch;
    // an always_comb with a missing else branch would.
    assign bus.DM_data = w_rd_en ? w_rdata : ZERO_WORD;

endmodule : data_memory

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
// Purpose : self-checking bench for data_memory. A plain array model computes
//           expected contents from byte-address arithmetic; directed scenarios
//           are followed by a randomized mix of reads and writes.
// ----------------------------------------------------------------------------
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk;
    logic rst;
    data_memory_if bus ();

    data_memory #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [31:0] ref_mem [DEPTH];

    function automatic bit in_range(input logic [31:0] a);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        return a < DEPTH * 4;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
        if (!rd || !in_range(a)) return 32'h0;
        return ref_mem[word_of(a)];
    endfunction

    // One rising edge; the model applies the same edge using the held inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        end else if (bus.MemWrite && in_range(bus.addr)) begin
            ref_mem[word_of(bus.addr)] = bus.data;
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic rd, input logic wr);
        bus.addr     = a;
        bus.data     = d;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'd0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(32'd0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_addr0 got=%h exp=%h", bus.DM_data, 32'h0);
        end
        drive(32'd40, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'h0) begin
            n_bad++; $display("FAIL reset_addr40 got=%h exp=%h", bus.DM_data, 32'h0);
        end
    endtask

    task automatic test_alias();
        drive(32'd10, 32'd10, 1'b0, 1'b1);
        tick();
        drive(32'd10, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'd10) begin
            n_bad++; $display("FAIL alias_addr10 got=%h exp=%h", bus.DM_data, 32'd10);
        end
        drive(32'd8, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'd10) begin
            n_bad++; $display("FAIL alias_addr8 got=%h exp=%h", bus.DM_data, 32'd10);
        end
    endtask

    task automatic test_read_gate();
        drive(32'd4, 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        drive(32'd4, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'h0) begin
            n_bad++; $display("FAIL gate_rd0 got=%h exp=%h", bus.DM_data, 32'h0);
        end
        drive(32'd4, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL gate_rd1 got=%h exp=%h", bus.DM_data, 32'hDEADBEEF);
        end
        drive(32'd0, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'h0) begin
            n_bad++; $display("FAIL gate_word0 got=%h exp=%h", bus.DM_data, 32'h0);
        end
    endtask

    task automatic test_read_during_write();
        drive(32'd12, 32'd5, 1'b0, 1'b1);
        tick();
        drive(32'd12, 32'd7, 1'b1, 1'b1);
        n_cmp++;
        if (bus.DM_data !== 32'd5) begin
            n_bad++; $display("FAIL rdw_before got=%h exp=%h", bus.DM_data, 32'd5);
        end
        tick();
        n_cmp++;
        if (bus.DM_data !== 32'd7) begin
            n_bad++; $display("FAIL rdw_after got=%h exp=%h", bus.DM_data, 32'd7);
        end
        drive(32'd12, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        drive(32'd0, 32'h0000_1111, 1'b0, 1'b1);
        tick();
        drive(32'd1024, 32'd3, 1'b0, 1'b1);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        n_cmp++;
        if (bus.addr_err !== 1'b1) begin
            n_bad++; $display("FAIL wrap_addr_err got=%b exp=1", bus.addr_err);
        end
`endif
        tick();
        drive(32'd0, 32'h0, 1'b1, 1'b0);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
        n_cmp++;
        if (bus.DM_data !== 32'h0000_1111) begin
            n_bad++; $display("FAIL wrap_word0 got=%h exp=%h", bus.DM_data, 32'h0000_1111);
        end
        drive(32'd1024, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'h0) begin
            n_bad++; $display("FAIL wrap_oob_read got=%h exp=%h", bus.DM_data, 32'h0);
        end
`else
        n_cmp++;
        if (bus.DM_data !== 32'd3) begin
            n_bad++; $display("FAIL wrap_word0 got=%h exp=%h", bus.DM_data, 32'd3);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, DEPTH * 4 - 1)) : $urandom;
            drive(a, $urandom, 1'($urandom), 1'($urandom));
            exp = model_read(a, bus.MemRead);
            n_cmp++;
            if (bus.DM_data !== exp) begin
                n_bad++; $display("FAIL rand_read n=%0d addr=%h got=%h exp=%h", n, a, bus.DM_data, exp);
            end
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
            n_cmp++;
            if (bus.addr_err !== (!in_range(a) && (bus.MemRead || bus.MemWrite))) begin
                n_bad++; $display("FAIL rand_addr_err n=%0d addr=%h got=%b", n, a, bus.addr_err);
            end
`endif
            tick();
        end
        drive(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            drive(32'(i * 4), 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (bus.DM_data !== ref_mem[i]) begin
                n_bad++; $display("FAIL %s word=%0d got=%h exp=%h", tag, i, bus.DM_data, ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(32'd16, 32'd9, 1'b0, 1'b1);
        tick();
        drive(32'd16, 32'h0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.DM_data !== 32'd9) begin
            n_bad++; $display("FAIL rstpri_pre got=%h exp=%h", bus.DM_data, 32'd9);
        end
        rst = 1'b1;
        drive(32'd20, 32'd9, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        drive(32'd20, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            drive(32'(i * 4), 32'h0, 1'b1, 1'b0);
            n_cmp++;
            if (bus.DM_data !== 32'h0) begin
                n_bad++; $display("FAIL rstpri_word=%0d got=%h exp=%h", i, bus.DM_data, 32'h0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.addr = '0; bus.data = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_alias();
        test_read_gate();
        test_read_during_write();
        test_wrap();
        test_random();
        sweep("rand_sweep");
        test_reset_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_data_memory
